// File: rtl/bg_layer_sequencer_pkg.sv
// Shared definitions for the background layer sequencer: state encoding,
// register map indices, CTRL bit positions and the default layer count.
package bg_seq_pkg;

    localparam int DEFAULT_NUM_LAYERS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHOW  = 2'd2,
        ST_BLANK = 2'd3
    } state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DWELL  = 2'd1;
    localparam logic [1:0] REG_SPEED  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_AUTO     = 1;
    localparam int CTRL_START_LO = 2;
    localparam int CTRL_START_HI = 3;
    localparam int CTRL_IRQ_EN   = 4;
    localparam int CTRL_W        = 5;

    // Round-robin successor of a layer index.
    function automatic logic [1:0] next_layer(input logic [1:0] cur, input logic [1:0] last);
        return (cur == last) ? 2'd0 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/bg_layer_sequencer_if.sv
// Software register port of the background layer sequencer: write strobe,
// index and data, plus combinational read-back.
interface bg_layer_sequencer_if;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;

    modport master (output cfg_wr, output cfg_addr, output cfg_wdata, input cfg_rdata);
    modport slave  (input cfg_wr, input cfg_addr, input cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/bg_layer_sequencer_frame_tick.sv
// Frame boundary detector: one-cycle tick on the leading edge of vsync into
// its active level.
module bg_frame_tick #(
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic tick
);

    logic vsync_q;

    // Resetting to the active level suppresses a spurious tick when vsync is
    // already asserted as reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= VSYNC_POL;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign tick = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);

endmodule

// File: rtl/bg_layer_sequencer.sv
// Frame-synchronous background layer sequencer: layer select, per-frame scroll
// and auto-cycling with blank frames. BG_SEQ_SCROLL_Y_EN enables vertical scroll.
module bg_layer_sequencer
    import bg_seq_pkg::*;
#(
    parameter int NUM_LAYERS   = DEFAULT_NUM_LAYERS,
    parameter int SCROLL_W     = 11,
    parameter int BLANK_FRAMES = 2,
    parameter bit VSYNC_POL    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bg_layer_sequencer_if.slave   cfg,
    input  logic                  vsync,
    input  logic                  irq_clr,
    output logic                  vga_en,
    output logic [NUM_LAYERS-1:0] layer_sel,
    output logic [SCROLL_W-1:0]   scroll_x,
    output logic [SCROLL_W-1:0]   scroll_y,
    output logic                  frame_irq
);

    localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_FRAMES - 1);
`ifdef BG_SEQ_SCROLL_Y_EN
    localparam int SPEED_W = 8;
`else
    localparam int SPEED_W = 4;
`endif

    logic                tick;
    logic [CTRL_W-1:0]   ctrl_q;
    logic [7:0]          dwell_q;
    logic [SPEED_W-1:0]  speed_q;
    state_e              state_q, state_d;
    logic [1:0]          layer_q, layer_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [SCROLL_W-1:0] scroll_x_q, scroll_x_d;
`ifdef BG_SEQ_SCROLL_Y_EN
    logic [SCROLL_W-1:0] scroll_y_q, scroll_y_d;
`endif
    logic                irq_q, irq_d, irq_set;
    logic                run, auto_cycle, irq_en, show_act;
    logic [1:0]          start_raw, start_layer;

    bg_frame_tick #(.VSYNC_POL(VSYNC_POL)) u_frame_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .vsync (vsync),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            dwell_q <= '0;
            speed_q <= '0;
        end else if (cfg.cfg_wr) begin
            case (cfg.cfg_addr)
                REG_CTRL:  ctrl_q  <= cfg.cfg_wdata[CTRL_W-1:0];
                REG_DWELL: dwell_q <= cfg.cfg_wdata[7:0];
                REG_SPEED: speed_q <= cfg.cfg_wdata[SPEED_W-1:0];
                default:   ;
            endcase
        end
    end

    assign run         = ctrl_q[CTRL_RUN];
    assign auto_cycle  = ctrl_q[CTRL_AUTO];
    assign irq_en      = ctrl_q[CTRL_IRQ_EN];
    assign start_raw   = ctrl_q[CTRL_START_HI:CTRL_START_LO];
    assign start_layer = (start_raw > LAST_LAYER) ? 2'd0 : start_raw;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            layer_q     <= '0;
            frame_cnt_q <= '0;
            scroll_x_q  <= '0;
`ifdef BG_SEQ_SCROLL_Y_EN
            scroll_y_q  <= '0;
`endif
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            frame_cnt_q <= frame_cnt_d;
            scroll_x_q  <= scroll_x_d;
`ifdef BG_SEQ_SCROLL_Y_EN
            scroll_y_q  <= scroll_y_d;
`endif
            irq_q       <= irq_d;
        end
    end

    // FSM next state; the scroll step is SPEED as sampled at the tick itself,
    // so a mid-frame write is applied from the next frame boundary.
    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        frame_cnt_d = frame_cnt_q;
        scroll_x_d  = scroll_x_q;
`ifdef BG_SEQ_SCROLL_Y_EN
        scroll_y_d  = scroll_y_q;
`endif
        irq_set     = 1'b0;
        if (!run) begin
            state_d     = ST_IDLE;
            frame_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_SYNC;
                    frame_cnt_d = '0;
                end
                ST_SYNC: if (tick) begin
                    layer_d     = start_layer;
                    scroll_x_d  = '0;
`ifdef BG_SEQ_SCROLL_Y_EN
                    scroll_y_d  = '0;
`endif
                    frame_cnt_d = '0;
                    state_d     = ST_SHOW;
                end
                ST_SHOW: if (tick) begin
                    scroll_x_d = scroll_x_q + SCROLL_W'(speed_q[3:0]);
`ifdef BG_SEQ_SCROLL_Y_EN
                    scroll_y_d = scroll_y_q + SCROLL_W'(speed_q[7:4]);
`endif
                    if (auto_cycle && (dwell_q != 8'd0) && (frame_cnt_q == dwell_q - 8'd1)) begin
                        frame_cnt_d = '0;
                        state_d     = ST_BLANK;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                ST_BLANK: if (tick) begin
                    if (frame_cnt_q == BLANK_LAST) begin
                        layer_d     = next_layer(layer_q, LAST_LAYER);
                        frame_cnt_d = '0;
                        state_d     = ST_SHOW;
                        irq_set     = irq_en;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        irq_d = irq_set | (irq_q & ~irq_clr);
    end

    // FSM outputs; gating on run blanks the display in the same cycle run drops
    always_comb begin
        vga_en    = run && (state_q != ST_IDLE);
        show_act  = run && (state_q == ST_SHOW);
        scroll_x  = scroll_x_q;
        frame_irq = irq_q;
    end

`ifdef BG_SEQ_SCROLL_Y_EN
    assign scroll_y = scroll_y_q;
`else
    assign scroll_y = '0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_sel
            assign layer_sel[gi] = show_act && (layer_q == 2'(gi));
        end
    endgenerate

    always_comb begin
        cfg.cfg_rdata = '0;
        case (cfg.cfg_addr)
            REG_CTRL:   cfg.cfg_rdata[CTRL_W-1:0]  = ctrl_q;
            REG_DWELL:  cfg.cfg_rdata[7:0]         = dwell_q;
            REG_SPEED:  cfg.cfg_rdata[SPEED_W-1:0] = speed_q;
            REG_STATUS: begin
                cfg.cfg_rdata[1:0]  = state_q;
                cfg.cfg_rdata[3:2]  = layer_q;
                cfg.cfg_rdata[11:4] = frame_cnt_q;
            end
            default: cfg.cfg_rdata = '0;
        endcase
    end

endmodule
